// File: rtl/register_file_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : register_file_module                                          |
// | Description : DEPTH x DATA_SIZE register bank, one byte-enabled synchronous |
// |               write port, two combinational read ports, optional zero word. |
// |               Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module register_file_module #(
  parameter int   DATA_SIZE = 32,
  parameter int   DEPTH     = 32,
  parameter logic INIT      = 1'b1,
  parameter int   ZERO_REG  = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       WRITE,
  input  logic [$clog2(DEPTH)-1:0]   W_ADDR,
  input  logic [DATA_SIZE/8-1:0]     W_BE,
  input  logic [DATA_SIZE-1:0]       IN_DATA,
  input  logic [$clog2(DEPTH)-1:0]   R_ADDR_A,
  input  logic [$clog2(DEPTH)-1:0]   R_ADDR_B,
  output logic [DATA_SIZE-1:0]       OUT_DATA_A,
  output logic [DATA_SIZE-1:0]       OUT_DATA_B
);

  localparam int c_AW    = $clog2(DEPTH);
  localparam int c_NB    = DATA_SIZE / 8;
  // First word that behaves as real storage; word 0 is excluded when hardwired to zero.
  localparam int c_FIRST = (ZERO_REG != 0) ? 1 : 0;

  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]     w_wr_sel;
  logic [DATA_SIZE-1:0] w_rd_a;
  logic [DATA_SIZE-1:0] w_rd_b;

  // One-hot write decode; out-of-range and zero-word addresses select nothing.
  always_comb begin
    w_wr_sel = '0;
    for (int i = c_FIRST; i < DEPTH; i++) begin
      if (WRITE && (W_ADDR == c_AW'(i))) begin
        w_wr_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i < c_FIRST) ? '0 : {DATA_SIZE{INIT}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int b = 0; b < c_NB; b++) begin
          if (w_wr_sel[i] && W_BE[b]) begin
            r_mem[i][8*b +: 8] <= IN_DATA[8*b +: 8];
          end
        end
      end
    end
  end

  // Read muxes default to zero, which covers both out-of-range and zero-word reads.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = c_FIRST; i < DEPTH; i++) begin
      if (R_ADDR_A == c_AW'(i)) begin
        w_rd_a = r_mem[i];
      end
      if (R_ADDR_B == c_AW'(i)) begin
        w_rd_b = r_mem[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [DATA_SIZE-1:0] w_wr_old;
  logic [DATA_SIZE-1:0] w_merged;
  logic                 w_wr_live;

  always_comb begin
    w_wr_old = '0;
    for (int i = c_FIRST; i < DEPTH; i++) begin
      if (W_ADDR == c_AW'(i)) begin
        w_wr_old = r_mem[i];
      end
    end
    w_merged = w_wr_old;
    for (int b = 0; b < c_NB; b++) begin
      if (W_BE[b]) begin
        w_merged[8*b +: 8] = IN_DATA[8*b +: 8];
      end
    end
  end

  // A live write already implies in-range, non-zero-word target.
  assign w_wr_live  = (|w_wr_sel) && !RST;
  assign OUT_DATA_A = (w_wr_live && (R_ADDR_A == W_ADDR)) ? w_merged : w_rd_a;
  assign OUT_DATA_B = (w_wr_live && (R_ADDR_B == W_ADDR)) ? w_merged : w_rd_b;
`else
  assign OUT_DATA_A = w_rd_a;
  assign OUT_DATA_B = w_rd_b;
`endif

endmodule
`default_nettype wire

// File: tb/tb_register_file_module.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_register_file_module                                       |
// | Description : Directed + random scoreboard bench for register_file_module   |
// |               (DEPTH=20 so out-of-range addresses are reachable).           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_register_file_module;

  localparam int DW    = 32;
  localparam int DEPTH = 20;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          write;
  logic [AW-1:0] w_addr;
  logic [3:0]    be;
  logic [DW-1:0] din;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [DW-1:0] oa;
  logic [DW-1:0] ob;

  always #5 clk = ~clk;

  register_file_module #(
    .DATA_SIZE(DW),
    .DEPTH    (DEPTH),
    .INIT     (1'b1),
    .ZERO_REG (1)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .WRITE     (write),
    .W_ADDR    (w_addr),
    .W_BE      (be),
    .IN_DATA   (din),
    .R_ADDR_A  (ra),
    .R_ADDR_B  (rb),
    .OUT_DATA_A(oa),
    .OUT_DATA_B(ob)
  );

  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] exp_q [$];
  string         tag_q [$];
  int            checks   = 0;
  int            failures = 0;

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 0 || a >= DEPTH) return '0;
    return model[a];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [3:0]    m);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic push(input string tag, input logic [DW-1:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input logic [DW-1:0] obs);
    string         t;
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%08h expected=<none>", obs);
      return;
    end
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", t, obs, e);
    end
  endtask

  // Drive read addresses mid-cycle and compare both ports against the model.
  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b);
    @(negedge clk);
    ra = a;
    rb = b;
    push({tag, "_A"}, model_rd(a));
    push({tag, "_B"}, model_rd(b));
    #1;
    pop_check(oa);
    pop_check(ob);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] m);
    @(negedge clk);
    write  = 1'b1;
    w_addr = a;
    din    = d;
    be     = m;
    @(posedge clk);
    if (a != 0 && a < DEPTH) model[a] = merge(model[a], d, m);
    #1;
    write = 1'b0;
  endtask

  task automatic do_reset(input logic with_write, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    rst    = 1'b1;
    write  = with_write;
    w_addr = a;
    din    = d;
    be     = 4'hF;
    @(posedge clk);
    for (int i = 0; i < DEPTH; i++) model[i] = (i == 0) ? '0 : '1;
    #1;
    rst   = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    rst    = 1'b0;
    write  = 1'b0;
    w_addr = '0;
    be     = '0;
    din    = '0;
    ra     = '0;
    rb     = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 'x;

    // Reset fill
    do_reset(1'b0, '0, '0);
    read_check("rst_fill_0_5", 5'd0, 5'd5);
    read_check("rst_fill_19_3", 5'd19, 5'd3);

    // Byte-enable merge
    do_write(5'd7, 32'h12345678, 4'b1111);
    read_check("wr_full", 5'd7, 5'd7);
    do_write(5'd7, 32'hAABBCCDD, 4'b0101);
    read_check("wr_bytes", 5'd7, 5'd6);
    do_write(5'd7, 32'h00000000, 4'b0000);
    read_check("wr_be0", 5'd7, 5'd1);

    // Zero register: check during the write cycle and after it
    @(negedge clk);
    write = 1'b1; w_addr = 5'd0; din = 32'hDEADBEEF; be = 4'hF;
    ra = 5'd0; rb = 5'd0;
    push("zero_during_A", 32'h0);
    push("zero_during_B", 32'h0);
    #1;
    pop_check(oa);
    pop_check(ob);
    @(posedge clk);
    #1;
    write = 1'b0;
    read_check("zero_after", 5'd0, 5'd0);

    // Collision on address 3; port B reads an unrelated word
    do_write(5'd3, 32'h11111111, 4'hF);
    @(negedge clk);
    write = 1'b1; w_addr = 5'd3; din = 32'h22222222; be = 4'hF;
    ra = 5'd3; rb = 5'd7;
`ifdef REGFILE_BYPASS_EN
    push("collide_same_A", 32'h22222222);
`else
    push("collide_same_A", 32'h11111111);
`endif
    push("collide_same_B", model_rd(5'd7));
    #1;
    pop_check(oa);
    pop_check(ob);
    @(posedge clk);
    model[3] = 32'h22222222;
    #1;
    write = 1'b0;
    read_check("collide_next", 5'd3, 5'd3);

    // Out of range
    do_write(5'd25, 32'hCAFEF00D, 4'hF);
    read_check("oor_25_20", 5'd25, 5'd20);
    read_check("oor_31_19", 5'd31, 5'd19);
    for (int i = 0; i < DEPTH; i += 2)
      read_check("oor_sweep", 5'(i), 5'(i + 1));

    // Reset wins over a simultaneous write
    do_write(5'd9, 32'h55555555, 4'hF);
    read_check("pre_rst_9", 5'd9, 5'd3);
    do_reset(1'b1, 5'd9, 32'h00000000);
    read_check("rst_vs_wr", 5'd9, 5'd7);
    read_check("rst_vs_wr0", 5'd0, 5'd3);

    // Random writes with random byte enables, interleaved with reads
    for (int n = 0; n < 40; n++) begin
      do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)));
      if (n % 2 == 1) read_check("rand", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    for (int i = 0; i < DEPTH; i += 2)
      read_check("final_sweep", 5'(i), 5'(i + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
